draw_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the rectangle draw stage. It decides what must be painted on the 160x120 screen and issues one rectangle command at a time: press slot or garbage slot, position 0–3, draw or erase. It then waits for the draw stage to finish before issuing the next. It keeps a shadow of which press rectangles are currently on screen, runs an erase sweep after reset, and arbitrates between garbage requests from game logic and press-state changes.

---
 rtl/draw_sequencer.sv | 154 +++++++++++++++
 tb/tb_draw_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sequencer.sv
// Command sequencer for the rectangle draw stage. It runs an erase sweep after reset,
// then reconciles the press display with press_state and services garbage requests.
module draw_sequencer #(
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] press_state,
  input  logic       gar_req,
  input  logic       gar_show,
  input  logic [1:0] gar_pos,
  input  logic       draw_done,
  output logic       item,
  output logic       erase,
  output logic [1:0] position,
  output logic       draw_start,
  output logic       gar_ack,
  output logic       busy,
  output logic       draw_err
);

  localparam int CNT_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_INIT_LOAD, ST_ISSUE, ST_WAIT, ST_IDLE} state_t;
  typedef enum logic [1:0] {SRC_INIT, SRC_PRESS, SRC_GAR} src_t;

  state_t           state_q, state_d;
  src_t             src_q, src_d;
  logic [3:0]       shadow_q, shadow_d;
  logic [2:0]       init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             item_q, item_d;
  logic             erase_q, erase_d;
  logic [1:0]       position_q, position_d;
  logic             draw_start_q, draw_start_d;
  logic             gar_ack_q, gar_ack_d;
  logic             busy_q, busy_d;
  logic             draw_err_q, draw_err_d;

  logic [3:0]       diff;
  logic [1:0]       low_idx;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    shadow_d     = shadow_q;
    init_cnt_d   = init_cnt_q;
    tcnt_d       = tcnt_q;
    item_d       = item_q;
    erase_d      = erase_q;
    position_d   = position_q;
    draw_err_d   = draw_err_q;
    draw_start_d = 1'b0;
    gar_ack_d    = 1'b0;

    // Lowest index where the screen disagrees with the requested press state
    diff    = press_state ^ shadow_q;
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (diff[i]) low_idx = 2'(i);
    end

    case (state_q)
      ST_INIT_LOAD: begin
        item_d       = ~init_cnt_q[2];
        position_d   = init_cnt_q[1:0];
        erase_d      = 1'b1;
        src_d        = SRC_INIT;
        draw_start_d = 1'b1;
        state_d      = ST_ISSUE;
      end
      ST_ISSUE: begin
        tcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (draw_done || tcnt_q == CNT_LAST) begin
          if (!draw_done) draw_err_d = 1'b1;
          state_d = ST_IDLE;
          case (src_q)
            SRC_INIT: begin
              init_cnt_d = init_cnt_q + 3'd1;
              if (init_cnt_q != 3'd7) state_d = ST_INIT_LOAD;
            end
            SRC_PRESS: shadow_d[position_q] = ~erase_q;
            default:   gar_ack_d = 1'b1;
          endcase
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end
      default: begin
        // Garbage requests outrank press reconciliation
        if (gar_req) begin
          item_d       = 1'b0;
          position_d   = gar_pos;
          erase_d      = ~gar_show;
          src_d        = SRC_GAR;
          draw_start_d = 1'b1;
          state_d      = ST_ISSUE;
        end else if (diff != 4'd0) begin
          item_d       = 1'b1;
          position_d   = low_idx;
          erase_d      = ~press_state[low_idx];
          src_d        = SRC_PRESS;
          draw_start_d = 1'b1;
          state_d      = ST_ISSUE;
        end
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT_LOAD;
      src_q        <= SRC_INIT;
      shadow_q     <= 4'd0;
      init_cnt_q   <= 3'd0;
      tcnt_q       <= '0;
      item_q       <= 1'b1;
      erase_q      <= 1'b1;
      position_q   <= 2'd0;
      draw_start_q <= 1'b0;
      gar_ack_q    <= 1'b0;
      busy_q       <= 1'b1;
      draw_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      shadow_q     <= shadow_d;
      init_cnt_q   <= init_cnt_d;
      tcnt_q       <= tcnt_d;
      item_q       <= item_d;
      erase_q      <= erase_d;
      position_q   <= position_d;
      draw_start_q <= draw_start_d;
      gar_ack_q    <= gar_ack_d;
      busy_q       <= busy_d;
      draw_err_q   <= draw_err_d;
    end
  end

  assign item       = item_q;
  assign erase      = erase_q;
  assign position   = position_q;
  assign draw_start = draw_start_q;
  assign gar_ack    = gar_ack_q;
  assign busy       = busy_q;
  assign draw_err   = draw_err_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: init sweep, directed vector table, randomized commands
// against a transaction-level model, timeout, ignored draw_done and mid-WAIT reset.
module tb_draw_sequencer;

  localparam int DONE_TIMEOUT = 4096;

  typedef struct {
    logic       item;
    logic [1:0] pos;
    logic       erase;
  } cmd_t;

  typedef struct {
    logic [3:0] press;
    logic       greq;
    logic       gshow;
    logic [1:0] gpos;
    bit         valid;
    cmd_t       cmd;
    logic [3:0] shadow;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] press_state;
  logic       gar_req;
  logic       gar_show;
  logic [1:0] gar_pos;
  logic       draw_done;
  logic       item;
  logic       erase;
  logic [1:0] position;
  logic       draw_start;
  logic       gar_ack;
  logic       busy;
  logic       draw_err;

  logic       resp_pulse   = 1'b0;
  logic       manual_pulse = 1'b0;
  logic       resp_en      = 1'b0;
  int         resp_delay   = 5;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] shadow_m;
  cmd_t       init_tab[8];
  vec_t       vecs[9];

  assign draw_done = resp_pulse | manual_pulse;

  always #5 clk = ~clk;

  draw_sequencer #(.DONE_TIMEOUT(DONE_TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .press_state (press_state),
    .gar_req     (gar_req),
    .gar_show    (gar_show),
    .gar_pos     (gar_pos),
    .draw_done   (draw_done),
    .item        (item),
    .erase       (erase),
    .position    (position),
    .draw_start  (draw_start),
    .gar_ack     (gar_ack),
    .busy        (busy),
    .draw_err    (draw_err)
  );

  // Draw-stage stand-in: answers each draw_start with a done pulse resp_delay cycles later
  initial begin
    forever begin
      @(negedge clk);
      if (resp_en && draw_start && reset_n) begin
        repeat (resp_delay) @(negedge clk);
        if (resp_en && reset_n) begin
          resp_pulse = 1'b1;
          @(negedge clk);
          resp_pulse = 1'b0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitIdle(input string name, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_idle_timeout: busy still 1 after %0d cycles, expected 0", name, budget);
    end
  endtask

  // Reference: the command the sequencer must pick in IDLE for these inputs
  function automatic void predict(input logic [3:0] sh, input logic [3:0] pr, input logic greq,
                                  input logic gshow, input logic [1:0] gpos,
                                  output bit valid, output cmd_t c);
    valid = 1'b0;
    c = '{1'b1, 2'd0, 1'b1};
    if (greq) begin
      valid = 1'b1;
      c = '{1'b0, gpos, !gshow};
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pr[i] != sh[i]) begin
          valid = 1'b1;
          c = '{1'b1, 2'(i), !pr[i]};
          break;
        end
      end
    end
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_item"},       32'(item),         32'(1));
    checkOutput({tag, "_erase"},      32'(erase),        32'(1));
    checkOutput({tag, "_position"},   32'(position),     32'(0));
    checkOutput({tag, "_draw_start"}, 32'(draw_start),   32'(0));
    checkOutput({tag, "_gar_ack"},    32'(gar_ack),      32'(0));
    checkOutput({tag, "_busy"},       32'(busy),         32'(1));
    checkOutput({tag, "_draw_err"},   32'(draw_err),     32'(0));
    checkOutput({tag, "_shadow"},     32'(dut.shadow_q), 32'(0));
  endtask

  // Called at the negedge where reset_n was just released; responder uses a 5-cycle delay
  task automatic checkInitSweep(input string tag);
    for (int k = 0; k < 8; k++) begin
      if (k == 0) @(negedge clk);
      else repeat (7) @(negedge clk);
      checkOutput($sformatf("%s_init%0d_start", tag, k), 32'(draw_start), 32'(1));
      checkOutput($sformatf("%s_init%0d_item", tag, k),  32'(item),       32'(init_tab[k].item));
      checkOutput($sformatf("%s_init%0d_pos", tag, k),   32'(position),   32'(init_tab[k].pos));
      checkOutput($sformatf("%s_init%0d_erase", tag, k), 32'(erase),      32'(init_tab[k].erase));
    end
    repeat (5) @(negedge clk);
    checkOutput({tag, "_busy_at_last_done"}, 32'(busy), 32'(1));
    @(negedge clk);
    checkOutput({tag, "_busy_after_sweep"}, 32'(busy), 32'(0));
    checkOutput({tag, "_shadow_after_sweep"}, 32'(dut.shadow_q), 32'(0));
  endtask

  task automatic applyStimulus(input string tag, input logic [3:0] pr, input logic greq,
                               input logic gshow, input logic [1:0] gpos, input bit exp_valid,
                               input cmd_t exp_c, input logic [3:0] exp_sh);
    bit ok;
    waitIdle(tag, 200, ok);
    press_state = pr;
    gar_req     = greq;
    gar_show    = gshow;
    gar_pos     = gpos;
    @(negedge clk);
    if (!exp_valid) begin
      checkOutput({tag, "_no_start"}, 32'(draw_start), 32'(0));
      checkOutput({tag, "_stay_idle"}, 32'(busy), 32'(0));
    end else begin
      checkOutput({tag, "_start"}, 32'(draw_start), 32'(1));
      checkOutput({tag, "_item"},  32'(item),       32'(exp_c.item));
      checkOutput({tag, "_pos"},   32'(position),   32'(exp_c.pos));
      checkOutput({tag, "_erase"}, 32'(erase),      32'(exp_c.erase));
      waitIdle(tag, 200, ok);
      if (ok) begin
        checkOutput({tag, "_gar_ack"},  32'(gar_ack),  32'(greq));
        checkOutput({tag, "_pos_held"}, 32'(position), 32'(exp_c.pos));
      end
      gar_req = 1'b0;
    end
    checkOutput({tag, "_shadow"}, 32'(dut.shadow_q), 32'(exp_sh));
  endtask

  task automatic runModel(input string tag, input logic [3:0] pr, input logic greq,
                          input logic gshow, input logic [1:0] gpos);
    bit         v;
    cmd_t       c;
    logic [3:0] nsh;
    predict(shadow_m, pr, greq, gshow, gpos, v, c);
    nsh = shadow_m;
    if (v && c.item) nsh[c.pos] = !c.erase;
    applyStimulus(tag, pr, greq, gshow, gpos, v, c, nsh);
    shadow_m = nsh;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) init_tab[k] = '{(k < 4), 2'(k % 4), 1'b1};

    vecs[0] = '{4'b0101, 1'b0, 1'b0, 2'd0, 1'b1, '{1'b1, 2'd0, 1'b0}, 4'b0001};
    vecs[1] = '{4'b0101, 1'b0, 1'b0, 2'd0, 1'b1, '{1'b1, 2'd2, 1'b0}, 4'b0101};
    vecs[2] = '{4'b0001, 1'b0, 1'b0, 2'd0, 1'b1, '{1'b1, 2'd2, 1'b1}, 4'b0001};
    vecs[3] = '{4'b1001, 1'b1, 1'b1, 2'd3, 1'b1, '{1'b0, 2'd3, 1'b0}, 4'b0001};
    vecs[4] = '{4'b1001, 1'b0, 1'b0, 2'd0, 1'b1, '{1'b1, 2'd3, 1'b0}, 4'b1001};
    vecs[5] = '{4'b1001, 1'b1, 1'b0, 2'd1, 1'b1, '{1'b0, 2'd1, 1'b1}, 4'b1001};
    vecs[6] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, '{1'b1, 2'd0, 1'b1}, 4'b1000};
    vecs[7] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, '{1'b1, 2'd3, 1'b1}, 4'b0000};
    vecs[8] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, '{1'b1, 2'd0, 1'b1}, 4'b0000};

    reset_n     = 1'b0;
    press_state = 4'd0;
    gar_req     = 1'b0;
    gar_show    = 1'b0;
    gar_pos     = 2'd0;
    resp_en     = 1'b1;
    resp_delay  = 5;
    shadow_m    = 4'd0;

    $display("[TB] reset and init sweep");
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset_n = 1'b1;
    checkInitSweep("sweep1");

    $display("[TB] directed vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].press, vecs[i].greq, vecs[i].gshow,
                    vecs[i].gpos, vecs[i].valid, vecs[i].cmd, vecs[i].shadow);
    end
    shadow_m = 4'd0;

    $display("[TB] draw_done outside WAIT");
    manual_pulse = 1'b1;
    @(negedge clk);
    manual_pulse = 1'b0;
    checkOutput("done_in_idle_busy", 32'(busy), 32'(0));
    checkOutput("done_in_idle_ack", 32'(gar_ack), 32'(0));
    checkOutput("done_in_idle_shadow", 32'(dut.shadow_q), 32'(shadow_m));
    resp_en = 1'b0;
    press_state = shadow_m ^ 4'b0100;
    @(negedge clk);
    checkOutput("done_in_issue_start", 32'(draw_start), 32'(1));
    manual_pulse = 1'b1;
    @(negedge clk);
    manual_pulse = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("done_in_issue_still_busy", 32'(busy), 32'(1));
    checkOutput("done_in_issue_shadow", 32'(dut.shadow_q), 32'(shadow_m));
    manual_pulse = 1'b1;
    @(negedge clk);
    manual_pulse = 1'b0;
    shadow_m = shadow_m ^ 4'b0100;
    checkOutput("done_in_wait_idle", 32'(busy), 32'(0));
    checkOutput("done_in_wait_shadow", 32'(dut.shadow_q), 32'(shadow_m));
    checkOutput("done_in_wait_no_ack", 32'(gar_ack), 32'(0));
    resp_en = 1'b1;

    $display("[TB] randomized commands");
    for (int n = 0; n < 60; n++) begin
      resp_delay = $urandom_range(1, 6);
      runModel($sformatf("rand%0d", n), 4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
    resp_delay = 5;

    $display("[TB] draw_done timeout");
    begin
      bit ok;
      waitIdle("timeout_pre", 200, ok);
    end
    resp_en = 1'b0;
    press_state = shadow_m ^ 4'b0001;
    @(negedge clk);
    checkOutput("timeout_start", 32'(draw_start), 32'(1));
    repeat (DONE_TIMEOUT) @(negedge clk);
    checkOutput("timeout_last_wait_busy", 32'(busy), 32'(1));
    checkOutput("timeout_last_wait_err", 32'(draw_err), 32'(0));
    @(negedge clk);
    shadow_m = shadow_m ^ 4'b0001;
    checkOutput("timeout_exit_busy", 32'(busy), 32'(0));
    checkOutput("timeout_err", 32'(draw_err), 32'(1));
    checkOutput("timeout_shadow", 32'(dut.shadow_q), 32'(shadow_m));
    resp_en = 1'b1;
    runModel("after_timeout", shadow_m ^ 4'b0010, 1'b0, 1'b0, 2'd0);
    checkOutput("err_sticky", 32'(draw_err), 32'(1));

    $display("[TB] reset during WAIT");
    for (int k = 0; k < 4; k++) runModel($sformatf("prep%0d", k), 4'b0110, 1'b0, 1'b0, 2'd0);
    checkOutput("prep_shadow", 32'(dut.shadow_q), 32'(4'b0110));
    resp_en = 1'b0;
    press_state = 4'b1110;
    @(negedge clk);
    checkOutput("midwait_start", 32'(draw_start), 32'(1));
    repeat (3) @(negedge clk);
    press_state = 4'd0;
    #2;
    reset_n = 1'b0;
    #1;
    checkResetValues("midwait_reset");
    @(negedge clk);
    resp_en = 1'b1;
    reset_n = 1'b1;
    shadow_m = 4'd0;
    checkInitSweep("sweep2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
